// File: rtl/spi_sample_sequencer_pkg.sv
// Shared types and defaults for the SPI microphone sample sequencer.
package spi_seq_pkg;

  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned DEF_SAMPLE_DIV = 3125;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_TIMEOUT    = 2048;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    BUSY,
    PUSH
  } seq_state_t;

endpackage

// File: rtl/spi_sample_sequencer_fifo.sv
// First-word-fall-through sample FIFO; pointers carry one extra wrap bit.
module sample_fifo
  import spi_seq_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                sysclk,
  input  logic                reset_b,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic                full,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                empty,
  output logic [AW:0]         level
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; a write into a full FIFO is ignored.
  always_ff @(posedge sysclk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (wr_en && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_sample_sequencer.sv
// Sample-rate sequencer for the SPI microphone reader with output FIFO.
module spi_sample_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          sysclk,
  input  logic                          reset_b,
  input  logic                          enable,
  output logic                          sample,
  input  logic                          spi_cs_b,
  input  logic [SAMPLE_W-1:0]           spi_data,
  output logic [SAMPLE_W-1:0]           rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overrun,
  output logic                          timeout_err,
  input  logic                          clr_status
);

  localparam int unsigned   TW        = $clog2(SAMPLE_DIV);
  localparam int unsigned   BW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(TIMEOUT - 1);

  seq_state_t          state;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [BW-1:0]       busy_cnt;
  logic                cs_q;
  logic [SAMPLE_W-1:0] hold;
  logic                fifo_full;
  logic                fifo_empty;

  assign tick     = enable && (tick_cnt == TICK_LAST);
  assign rd_valid = !fifo_empty;

  // Free-running sample-rate divider, parked at zero while disabled.
  always_ff @(posedge sysclk or negedge reset_b) begin
    if (!reset_b) begin
      tick_cnt <= '0;
    end else if (!enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Frame sequencing FSM with registered strobe and sticky status flags.
  // Status clears are applied first so a same-cycle set overrides them.
  always_ff @(posedge sysclk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      sample      <= 1'b0;
      busy_cnt    <= '0;
      cs_q        <= 1'b1;
      hold        <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (clr_status) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable) state <= ARMED;
        end
        ARMED: begin
          if (tick) begin
            state  <= START;
            sample <= 1'b1;
          end else if (!enable) begin
            state <= IDLE;
          end
        end
        START: begin
          busy_cnt <= '0;
          cs_q     <= 1'b1;
          state    <= BUSY;
        end
        BUSY: begin
          cs_q <= spi_cs_b;
          if (!cs_q && spi_cs_b) begin
            hold  <= spi_data;
            state <= PUSH;
          end else if (busy_cnt == BUSY_LAST) begin
            timeout_err <= 1'b1;
            state       <= ARMED;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        PUSH: begin
          if (fifo_full) overrun <= 1'b1;
          state <= enable ? ARMED : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk  (sysclk),
    .reset_b (reset_b),
    .wr_en   (state == PUSH),
    .wr_data (hold),
    .full    (fifo_full),
    .rd_en   (rd_valid && rd_ready),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Scoreboard bench for spi_sample_sequencer with a behavioural SPI reader model.
module tb_spi_sample_sequencer;

  localparam int DIV   = 100;
  localparam int DEPTH = 16;
  localparam int TMO   = 50;

  logic        sysclk      = 1'b0;
  logic        reset_b     = 1'b1;
  logic        enable      = 1'b0;
  logic        sample;
  logic        spi_cs_b    = 1'b1;
  logic [15:0] spi_data    = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready    = 1'b0;
  logic [4:0]  fill_level;
  logic        overrun;
  logic        timeout_err;
  logic        clr_status  = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus controls (written by the main sequence)
  int drain_mode = 0;   // 0: never ready, 1: always ready, 2: random
  int word_src   = 2;   // 0: random, 1: sequence 1,2,3.., 2: 0xA5C3
  int bus_mode   = 0;   // 0: normal frame, 1: hang (timeout), 2: hang until abort
  bit pop_req    = 1'b0;
  bit abort      = 1'b0;
  bit en_run     = 1'b0;
  int e_cyc      = 0;

  // set by the reader model
  int pop_cyc    = -1;

  // reference model state
  logic [15:0] mq[$];
  logic [15:0] pend_w[$];
  int          pend_c[$];
  int          to_c[$];
  bit          exp_ovr = 1'b0;
  bit          exp_to  = 1'b0;
  int          sample_cnt = 0;
  int          words_seen = 0;

  spi_sample_sequencer #(
    .SAMPLE_DIV (DIV),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .sysclk      (sysclk),
    .reset_b     (reset_b),
    .enable      (enable),
    .sample      (sample),
    .spi_cs_b    (spi_cs_b),
    .spi_data    (spi_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .fill_level  (fill_level),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .clr_status  (clr_status)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_sample(output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge sysclk);
      if (sample === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_sample: got no pulse expected pulse within 400 cycles (cycle %0d)", cyc);
    end
  endtask

  // Consumer: drives rd_ready per drain mode, plus a forced pop on a chosen cycle.
  always @(posedge sysclk) begin
    #1;
    if (cyc == pop_cyc)       rd_ready = 1'b1;
    else if (drain_mode == 0) rd_ready = 1'b0;
    else if (drain_mode == 1) rd_ready = 1'b1;
    else                      rd_ready = 1'($urandom_range(0, 1));
  end

  // SPI reader model: answers each sample strobe with a frame of random length.
  initial begin : reader
    int s, dly, len, mode;
    int seq_word;
    bit pop_done;
    logic [15:0] w;
    seq_word = 1;
    pop_done = 1'b0;
    forever begin
      @(negedge sysclk);
      if (reset_b && sample) begin
        s    = cyc;
        mode = bus_mode;
        dly  = $urandom_range(1, 10);
        repeat (dly) @(posedge sysclk);
        #1 spi_cs_b = 1'b0;
        if (mode == 0) begin
          len = $urandom_range(1, 30);
          repeat (len) @(posedge sysclk);
          #1;
          if (word_src == 0)      w = 16'($urandom);
          else if (word_src == 1) begin w = 16'(seq_word); seq_word++; end
          else                    w = 16'hA5C3;
          spi_data = w;
          spi_cs_b = 1'b1;
          pend_w.push_back(w);
          pend_c.push_back(cyc + 1);
          if (pop_req && !pop_done) begin
            pop_cyc  = cyc + 1;
            pop_done = 1'b1;
          end
        end else if (mode == 1) begin
          to_c.push_back(s + TMO);
          repeat (80 - dly) @(posedge sysclk);
          #1 spi_cs_b = 1'b1;
        end else begin
          for (int k = 0; k < 3000; k++) begin
            @(posedge sysclk);
            if (abort) break;
          end
          #1 spi_cs_b = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model, then advances the model.
  always @(negedge sysclk) begin
    int n;
    bit do_push;
    bit exp_s;
    logic [15:0] w;
    do_push = 1'b0;
    w       = '0;
    if (!reset_b) begin
      mq.delete();
      pend_w.delete();
      pend_c.delete();
      to_c.delete();
      exp_ovr = 1'b0;
      exp_to  = 1'b0;
    end else begin
      n = mq.size();
      chk("fill_level", 32'(fill_level), 32'(n));
      chk("rd_valid", 32'(rd_valid), 32'(n != 0));
      if (n != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
      exp_s = en_run && (cyc > e_cyc) && (((cyc - e_cyc) % DIV) == 0);
      chk("sample", 32'(sample), 32'(exp_s));
      if (sample === 1'b1) sample_cnt++;
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      chk("timeout_err", 32'(timeout_err), 32'(exp_to));

      if (clr_status) begin
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
      end
      if (pend_c.size() != 0 && pend_c[0] == cyc) begin
        void'(pend_c.pop_front());
        w = pend_w.pop_front();
        if (n < DEPTH) do_push = 1'b1;
        else           exp_ovr = 1'b1;
      end
      if (to_c.size() != 0 && to_c[0] == cyc) begin
        void'(to_c.pop_front());
        exp_to = 1'b1;
      end
      if (rd_ready && n != 0) begin
        void'(mq.pop_front());
        words_seen++;
      end
      if (do_push) mq.push_back(w);
    end
  end

  initial begin : main
    int s, s2, snap_s, snap_w, first;
    #2 reset_b = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_sample", 32'(sample), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    chk("reset_fill", 32'(fill_level), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_timeout", 32'(timeout_err), 0);
    reset_b = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    // fixed-pattern frames, always draining
    drain_mode = 1;
    enable     = 1'b1;
    e_cyc      = cyc;
    en_run     = 1'b1;
    repeat (520) @(posedge sysclk);
    // random words, random back-pressure
    #1;
    word_src   = 0;
    drain_mode = 2;
    repeat (1000) @(posedge sysclk);

    // fill: 17 sequential words with no draining
    wait_sample(s);
    repeat (60) @(posedge sysclk);
    #1 drain_mode = 1;
    repeat (20) @(posedge sysclk);
    #1;
    drain_mode = 0;
    word_src   = 1;
    repeat (1700) @(posedge sysclk);
    #1;
    chk("fill_full", 32'(fill_level), 16);
    chk("overrun_after_17", 32'(overrun), 1);

    // clear held across another dropped push, then drop with a pop on the push cycle
    clr_status = 1'b1;
    repeat (100) @(posedge sysclk);
    #1;
    clr_status = 1'b0;
    chk("overrun_cleared", 32'(overrun), 0);
    pop_req = 1'b1;
    repeat (100) @(posedge sysclk);
    #1;
    chk("fill_after_pop_drop", 32'(fill_level), 15);
    chk("overrun_pop_drop", 32'(overrun), 1);
    clr_status = 1'b1;
    @(posedge sysclk);
    #1 clr_status = 1'b0;
    chk("overrun_pulse_clr", 32'(overrun), 0);
    drain_mode = 1;
    repeat (60) @(posedge sysclk);

    // timeout frame followed by a normal frame
    #1 word_src = 0;
    wait_sample(s);
    repeat (60) @(posedge sysclk);
    #1 bus_mode = 1;
    wait_sample(s2);
    repeat (60) @(posedge sysclk);
    #1;
    bus_mode = 0;
    chk("timeout_set", 32'(timeout_err), 1);
    chk("timeout_no_write", 32'(fill_level), 0);
    clr_status = 1'b1;
    @(posedge sysclk);
    #1 clr_status = 1'b0;
    chk("timeout_cleared", 32'(timeout_err), 0);
    repeat (150) @(posedge sysclk);

    // drop enable in the middle of a frame
    wait_sample(s);
    for (int k = 0; k < 20; k++) begin
      @(negedge sysclk);
      if (!spi_cs_b) break;
    end
    @(posedge sysclk);
    #1;
    enable = 1'b0;
    en_run = 1'b0;
    snap_s = sample_cnt;
    snap_w = words_seen;
    repeat (300) @(posedge sysclk);
    #1;
    chk("no_sample_after_disable", 32'(sample_cnt), 32'(snap_s));
    chk("frame_completed", 32'(words_seen), 32'(snap_w + 1));

    // reset in the middle of a frame with 3 words buffered
    drain_mode = 0;
    enable     = 1'b1;
    e_cyc      = cyc;
    en_run     = 1'b1;
    repeat (350) @(posedge sysclk);
    #1 bus_mode = 2;
    wait_sample(s);
    for (int k = 0; k < 20; k++) begin
      @(negedge sysclk);
      if (!spi_cs_b) break;
    end
    repeat (2) @(posedge sysclk);
    #1;
    chk("fill_before_reset", 32'(fill_level), 3);
    #2 reset_b = 1'b0;
    #1;
    chk("areset_rd_valid", 32'(rd_valid), 0);
    chk("areset_rd_data", 32'(rd_data), 0);
    chk("areset_fill", 32'(fill_level), 0);
    chk("areset_sample", 32'(sample), 0);
    chk("areset_overrun", 32'(overrun), 0);
    chk("areset_timeout", 32'(timeout_err), 0);
    enable = 1'b0;
    en_run = 1'b0;
    abort  = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    reset_b  = 1'b1;
    abort    = 1'b0;
    bus_mode = 0;
    drain_mode = 1;
    enable   = 1'b1;
    e_cyc    = cyc;
    en_run   = 1'b1;
    first    = -1;
    for (int k = 0; k < 150; k++) begin
      @(negedge sysclk);
      if (sample === 1'b1) begin
        first = cyc - e_cyc;
        break;
      end
    end
    chk("first_sample_after_reset", 32'(first), DIV);
    repeat (150) @(posedge sysclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sample_sequencer.md
# spi_sample_sequencer

Sequences the SPI microphone reader at a fixed sample rate and buffers the captured 16-bit words. It issues a one-cycle `sample` strobe every `SAMPLE_DIV` sysclk cycles and watches the reader's `CS_b` for end-of-frame. Each completed word is pushed into a small FIFO drained through a valid/ready port. It sits between the SPI reader and the downstream audio consumer.

## Interface
- `SAMPLE_DIV`, 3125: sysclk cycles between sample ticks (50 MHz → 16 kHz); must be ≥ 2 and exceed one frame length.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `TIMEOUT`, 2048: maximum cycles in BUSY before the frame is abandoned.
- `sysclk`  in  1  system clock; all logic on rising edge.
- `reset_b`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run/stop request.
- `sample`  out  1  one-cycle start strobe to the SPI reader.
- `spi_cs_b`  in  1  reader chip select; low for the duration of a frame.
- `spi_data`  in  16  reader output word; valid once `spi_cs_b` returns high.
- `rd_data`  out  16  FIFO head word.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts the head word.
- `fill_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overrun`  out  1  sticky: a sample was dropped because the FIFO was full.
- `timeout_err`  out  1  sticky: a frame exceeded `TIMEOUT`.
- `clr_status`  in  1  one-cycle clear of both sticky flags.

## Operation
- Reset values: state IDLE; all counters 0; `sample`, `rd_valid`, `overrun` and `timeout_err` = 0; `rd_data` = 0; `fill_level` = 0. The FIFO is emptied.
- Tick counter:
  - Counts 0..`SAMPLE_DIV`-1 while `enable`=1 and wraps. A tick occurs on the cycle where count = `SAMPLE_DIV`-1.
  - Held at 0 while `enable`=0.
  - A tick arriving in any state other than ARMED is discarded.
- IDLE: when `enable`=1 → ARMED.
- ARMED:
  - On tick → START.
  - If `enable`=0 → IDLE.
- START: `sample`=1 for exactly this cycle; the busy counter is cleared → BUSY.
- BUSY:
  - `spi_cs_b` is registered into `cs_q`.
  - Rising edge (`cs_q`=0, `spi_cs_b`=1) → PUSH; `spi_data` is captured into the holding register that cycle.
  - The busy counter reaching `TIMEOUT` → set `timeout_err`; no push; go to ARMED.
- PUSH:
  - If the FIFO is full (evaluated before any same-cycle pop): drop the word and set `overrun`.
  - Otherwise write the word.
  - Then → ARMED, or → IDLE if `enable`=0.
- Deassertion of `enable` mid-frame has no effect until PUSH or timeout completes; frames are never truncated by this block.
- `clr_status` and a same-cycle set: the set wins.
- FIFO pointers are `$clog2(FIFO_DEPTH)`+1 bits with natural wrap; full/empty are determined by MSB compare.

## Timing
- Tick at cycle t in ARMED → `sample` high at t+1.
- The reader's `spi_cs_b` falls at t+2 at the earliest.
- Capture happens on the cycle the rising edge is seen; PUSH is the following cycle.
- Push at cycle p (FIFO previously empty) → `rd_valid`=1 and `rd_data` valid at p+1. There is no same-cycle fall-through.
- Pop occurs when `rd_valid`&&`rd_ready`. The next head word (or `rd_valid`=0) appears in the following cycle.
- Simultaneous push and pop when not full: `fill_level` is unchanged.
- `fill_level` updates one cycle after the push/pop edge.
- Async reset assertion clears everything immediately, including mid-frame.
- Reset deassertion is synchronized externally. The SPI reader must be reset concurrently by the system.

## Structure
- Package `spi_seq_pkg`:
  - state enum `seq_state_t` {IDLE, ARMED, START, BUSY, PUSH};
  - `SAMPLE_W` = 16;
  - default parameter constants.
- Sub-module `sample_fifo`:
  - synchronous FWFT FIFO with async active-low reset;
  - ports: `wr_en`, `wr_data`, `full`, `rd_en`, `rd_data`, `empty`, `level`.
- The top holds the tick counter, FSM, busy counter, `cs_q` and status flags.

## Test plan
- Reset then `enable`=1, `SAMPLE_DIV`=100, bus model returns 0xA5C3 → `sample` pulses exactly every 100 cycles; `rd_data`=0xA5C3 with `rd_valid` one cycle after PUSH.
- `rd_ready`=0 for 17 frames, `FIFO_DEPTH`=16, words 1..17 → `fill_level`=16; `overrun`=1 after the 17th PUSH; draining yields 1..16 in order.
- Bus model holds `spi_cs_b` low forever, `TIMEOUT`=50 → `timeout_err`=1 exactly 50 cycles into BUSY; no FIFO write; the next tick produces a normal frame.
- Full FIFO with a pop on the PUSH cycle → word still dropped; `overrun`=1; `fill_level`=15 next cycle.
- `enable` dropped mid-BUSY → the frame completes and is pushed; state → IDLE; no further `sample` pulses.
- `reset_b` asserted mid-BUSY with 3 words buffered → all outputs 0 asynchronously; `fill_level`=0; the first `sample` comes `SAMPLE_DIV` cycles after re-enable.
